// File: rtl/core_pkg.sv
// core_pkg: shared types and operation encodings for the RV32I execute stage.
//   ALU_OPERATIONS_*  8-bit operation codes produced by decode
//   ex_state_t        execute-stage FSM states (SHIFT/DONE used only with SERIAL_SHIFT_EN)
//   ex_result_t       contents of the EX->MEM output register
package core_pkg;

    localparam logic [7:0] ALU_OPERATIONS_NOP  = 8'h00;
    localparam logic [7:0] ALU_OPERATIONS_ADD  = 8'h01;
    localparam logic [7:0] ALU_OPERATIONS_SUB  = 8'h02;
    localparam logic [7:0] ALU_OPERATIONS_SLL  = 8'h03;
    localparam logic [7:0] ALU_OPERATIONS_SLT  = 8'h04;
    localparam logic [7:0] ALU_OPERATIONS_SLTU = 8'h05;
    localparam logic [7:0] ALU_OPERATIONS_XOR  = 8'h06;
    localparam logic [7:0] ALU_OPERATIONS_SRL  = 8'h07;
    localparam logic [7:0] ALU_OPERATIONS_SRA  = 8'h08;
    localparam logic [7:0] ALU_OPERATIONS_OR   = 8'h09;
    localparam logic [7:0] ALU_OPERATIONS_AND  = 8'h0A;
    localparam logic [7:0] ALU_OPERATIONS_LB   = 8'h10;
    localparam logic [7:0] ALU_OPERATIONS_LH   = 8'h11;
    localparam logic [7:0] ALU_OPERATIONS_LW   = 8'h12;
    localparam logic [7:0] ALU_OPERATIONS_LBU  = 8'h13;
    localparam logic [7:0] ALU_OPERATIONS_LHU  = 8'h14;
    localparam logic [7:0] ALU_OPERATIONS_SB   = 8'h18;
    localparam logic [7:0] ALU_OPERATIONS_SH   = 8'h19;
    localparam logic [7:0] ALU_OPERATIONS_SW   = 8'h1A;
    localparam logic [7:0] ALU_OPERATIONS_BEQ  = 8'h20;
    localparam logic [7:0] ALU_OPERATIONS_BNE  = 8'h21;
    localparam logic [7:0] ALU_OPERATIONS_BLT  = 8'h22;
    localparam logic [7:0] ALU_OPERATIONS_BGE  = 8'h23;
    localparam logic [7:0] ALU_OPERATIONS_BLTU = 8'h24;
    localparam logic [7:0] ALU_OPERATIONS_BGEU = 8'h25;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } ex_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [7:0]  operation;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        branch_taken;
        logic [31:0] branch_target;
    } ex_result_t;

    function automatic logic is_shift_op(input logic [7:0] op);
        return (op == ALU_OPERATIONS_SLL) || (op == ALU_OPERATIONS_SRL) ||
               (op == ALU_OPERATIONS_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational result, address and branch compare for one bundle.
//   in : operation, rs1_data, rs2_data, imm, pc, use_imm, rd_addr, reg_write
//   out: res (ex_result_t ready to be registered)
// With SERIAL_SHIFT_EN defined the shift ops return rs1_data unshifted; that is
// the correct answer for a zero shift amount, and non-zero amounts go through the
// iterative shifter in execute_stage instead.
module alu_core
    import core_pkg::*;
(
    input  logic [7:0]  operation,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        use_imm,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    output ex_result_t  res
);

    logic [31:0] op_b;
    logic [31:0] eff_addr;

    assign op_b     = use_imm ? imm : rs2_data;
    assign eff_addr = rs1_data + imm;

    always_comb begin
        res           = '0;
        res.operation = operation;
        res.rd_addr   = rd_addr;
        res.reg_write = reg_write;
        case (operation)
            ALU_OPERATIONS_ADD:  res.result = rs1_data + op_b;
            ALU_OPERATIONS_SUB:  res.result = rs1_data - op_b;
            ALU_OPERATIONS_SLT:  res.result = {31'b0, $signed(rs1_data) < $signed(op_b)};
            ALU_OPERATIONS_SLTU: res.result = {31'b0, rs1_data < op_b};
            ALU_OPERATIONS_XOR:  res.result = rs1_data ^ op_b;
            ALU_OPERATIONS_OR:   res.result = rs1_data | op_b;
            ALU_OPERATIONS_AND:  res.result = rs1_data & op_b;
`ifdef SERIAL_SHIFT_EN
            ALU_OPERATIONS_SLL,
            ALU_OPERATIONS_SRL,
            ALU_OPERATIONS_SRA:  res.result = rs1_data;
`else
            ALU_OPERATIONS_SLL:  res.result = rs1_data << op_b[4:0];
            ALU_OPERATIONS_SRL:  res.result = rs1_data >> op_b[4:0];
            ALU_OPERATIONS_SRA:  res.result = $unsigned($signed(rs1_data) >>> op_b[4:0]);
`endif
            ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW,
            ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU: res.result = eff_addr;
            ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW: begin
                res.result     = eff_addr;
                res.store_data = rs2_data;
                res.reg_write  = 1'b0;
            end
            ALU_OPERATIONS_BEQ, ALU_OPERATIONS_BNE, ALU_OPERATIONS_BLT,
            ALU_OPERATIONS_BGE, ALU_OPERATIONS_BLTU, ALU_OPERATIONS_BGEU: begin
                res.reg_write     = 1'b0;
                res.branch_target = pc + imm;
                case (operation)
                    ALU_OPERATIONS_BEQ:  res.branch_taken = (rs1_data == rs2_data);
                    ALU_OPERATIONS_BNE:  res.branch_taken = (rs1_data != rs2_data);
                    ALU_OPERATIONS_BLT:  res.branch_taken = ($signed(rs1_data) < $signed(rs2_data));
                    ALU_OPERATIONS_BGE:  res.branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
                    ALU_OPERATIONS_BLTU: res.branch_taken = (rs1_data < rs2_data);
                    default:             res.branch_taken = (rs1_data >= rs2_data);
                endcase
            end
            default: begin
                // NOP and any unrecognised code retire as a harmless NOP.
                res.operation = ALU_OPERATIONS_NOP;
                res.reg_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage with valid/ready on both sides and a
// registered EX->MEM result.
//   in : clk, rst_n (sync, active-low), in_valid, alu_operation, rs1_data,
//        rs2_data, imm, pc, use_imm, rd_addr, reg_write, flush, out_ready
//   out: in_ready, out_valid, out_result, out_store_data, out_operation,
//        out_rd_addr, out_reg_write, branch_taken, branch_target
// Optional macro SERIAL_SHIFT_EN: SLL/SRL/SRA with a non-zero amount use a
// 1-bit/cycle shifter (latency shamt+1, in_ready low until IDLE again).
module execute_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          alu_operation,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc,
    input  logic                use_imm,
    input  logic [REG_ADDR-1:0] rd_addr,
    input  logic                reg_write,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [XLEN-1:0]     out_store_data,
    output logic [7:0]          out_operation,
    output logic [REG_ADDR-1:0] out_rd_addr,
    output logic                out_reg_write,
    output logic                branch_taken,
    output logic [XLEN-1:0]     branch_target
);

    ex_state_t  state, state_next;
    ex_result_t alu_res, out_reg;
    logic       out_valid_q;
    logic       accept;

    alu_core u_alu (
        .operation (alu_operation),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .pc        (pc),
        .use_imm   (use_imm),
        .rd_addr   (rd_addr),
        .reg_write (reg_write),
        .res       (alu_res)
    );

    assign in_ready = rst_n && (state == IDLE) && (!out_valid_q || out_ready);
    // A bundle offered during flush is dropped, so it never counts as accepted.
    assign accept   = in_valid && in_ready && !flush;

`ifdef SERIAL_SHIFT_EN
    logic       start_shift;
    logic [4:0] shamt;
    logic [31:0] sh_val;
    logic [4:0]  sh_cnt;
    ex_result_t  sh_res;

    assign shamt       = use_imm ? imm[4:0] : rs2_data[4:0];
    assign start_shift = accept && is_shift_op(alu_operation) && (shamt != '0);

    // sh_res carries the bundle's metadata while sh_val is shifted in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_val <= '0;
            sh_cnt <= '0;
            sh_res <= '0;
        end else if (start_shift) begin
            sh_val <= rs1_data;
            sh_cnt <= shamt;
            sh_res <= alu_res;
        end else if (state == SHIFT && sh_cnt != '0) begin
            case (sh_res.operation)
                ALU_OPERATIONS_SLL: sh_val <= {sh_val[30:0], 1'b0};
                ALU_OPERATIONS_SRL: sh_val <= {1'b0, sh_val[31:1]};
                default:            sh_val <= {sh_val[31], sh_val[31:1]};
            endcase
            sh_cnt <= sh_cnt - 5'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
`ifdef SERIAL_SHIFT_EN
                IDLE:  if (start_shift) state_next = SHIFT;
                SHIFT: if (sh_cnt == '0) state_next = DONE;
                DONE:  if (out_ready) state_next = IDLE;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_reg     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
`ifdef SERIAL_SHIFT_EN
        end else if (accept && !start_shift) begin
`else
        end else if (accept) begin
`endif
            out_valid_q <= 1'b1;
            out_reg     <= alu_res;
`ifdef SERIAL_SHIFT_EN
        end else if (state == SHIFT && sh_cnt == '0) begin
            out_valid_q    <= 1'b1;
            out_reg        <= sh_res;
            out_reg.result <= sh_val;
`endif
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_reg.result;
    assign out_store_data = out_reg.store_data;
    assign out_operation  = out_reg.operation;
    assign out_rd_addr    = out_reg.rd_addr;
    assign out_reg_write  = out_reg.reg_write;
    assign branch_taken   = out_reg.branch_taken;
    assign branch_target  = out_reg.branch_target;

endmodule
